// File: rtl/vga_timing_ctrl_if.sv
// Control/status bundle for vga_timing_ctrl: count enable, shadow-register
// config port, and the registered video timing outputs.
// master = the side driving enable/config; slave = the timing generator.
interface vga_timing_ctrl_if #(
    parameter int CW = 16
);
    logic          en;
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [CW-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          frame_start;
    logic          line_start;
    logic          cfg_pend;
    logic          line_irq;

    modport master (
        output en, cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
        input  hsync, vsync, de, x, y, frame_start, line_start, cfg_pend, line_irq
    );

    modport slave (
        input  en, cfg_wr, cfg_addr, cfg_wdata, cfg_commit,
        output hsync, vsync, de, x, y, frame_start, line_start, cfg_pend, line_irq
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Purpose: VGA sync/DE generator with shadowed timing registers applied at frame end.
// Latency: outputs are registered on the same edge as the counters (zero added latency).
// Backpressure: none; en=0 freezes counters and outputs, pulse outputs drop to 0.
//
// Ports: clk (pixel clock), rst_n (synchronous active-low reset),
//   bus (vga_timing_ctrl_if.slave): en, cfg_wr/cfg_addr/cfg_wdata/cfg_commit in;
//   hsync, vsync, de, x, y, frame_start, line_start, cfg_pend, line_irq out.
// Register map: 0-7 = H_SYNC, H_BP, H_ACT, H_FP, V_SYNC, V_BP, V_ACT, V_FP (shadowed).
// Optional: define VGA_LINE_IRQ_EN to add lcmp at address 8 and the line_irq pulse.
module vga_timing_ctrl #(
    parameter int CW     = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_timing_ctrl_if.slave   bus
);
    localparam int NREG = 8;
    localparam logic [CW-1:0] DEF [NREG] = '{
        CW'(H_SYNC), CW'(H_BP), CW'(H_ACT), CW'(H_FP),
        CW'(V_SYNC), CW'(V_BP), CW'(V_ACT), CW'(V_FP)
    };

    logic [CW-1:0] act_q [NREG];
    logic [CW-1:0] act_d [NREG];
    logic [CW-1:0] shd_q [NREG];
    logic [CW-1:0] shd_d [NREG];
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic          pend_q, pend_d;

    logic          hsync_q, vsync_q, de_q, frame_start_q, line_start_q;
    logic [CW-1:0] x_q, y_q;

    logic [CW-1:0] htot, vtot;
    logic          h_last, v_last, copy;
    logic [CW-1:0] h_act_beg, h_act_end, v_act_beg, v_act_end;
    logic          de_d;

    always_comb begin
        htot   = act_q[0] + act_q[1] + act_q[2] + act_q[3];
        vtot   = act_q[4] + act_q[5] + act_q[6] + act_q[7];
        h_last = (hcnt_q == htot - CW'(1));
        v_last = (vcnt_q == vtot - CW'(1));
        // Timing swap only on the final pixel of a frame, so a frame never mixes timings.
        copy   = bus.en && h_last && v_last && pend_q;

        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (bus.en) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + CW'(1);
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end

        for (int i = 0; i < NREG; i++) begin
            act_d[i] = copy ? shd_q[i] : act_q[i];
            shd_d[i] = shd_q[i];
        end
        // Zero-length segments would break the counter wrap, so 0 is stored as 1.
        if (bus.cfg_wr && !bus.cfg_addr[3]) begin
            shd_d[bus.cfg_addr[2:0]] = (bus.cfg_wdata == '0) ? CW'(1) : bus.cfg_wdata;
        end

        // A commit on the copy edge wins so the new request is not lost.
        pend_d = bus.cfg_commit ? 1'b1 : (copy ? 1'b0 : pend_q);

        // Decode uses next-state counters and timing so outputs line up with the counters.
        h_act_beg = act_d[0] + act_d[1];
        h_act_end = h_act_beg + act_d[2];
        v_act_beg = act_d[4] + act_d[5];
        v_act_end = v_act_beg + act_d[6];
        de_d = (hcnt_d >= h_act_beg) && (hcnt_d < h_act_end) &&
               (vcnt_d >= v_act_beg) && (vcnt_d < v_act_end);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pend_q        <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                act_q[i] <= DEF[i];
                shd_q[i] <= DEF[i];
            end
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            if (bus.en) begin
                hsync_q       <= !(hcnt_d < act_d[0]);
                vsync_q       <= !(vcnt_d < act_d[4]);
                de_q          <= de_d;
                if (de_d) begin
                    x_q <= hcnt_d - h_act_beg;
                    y_q <= vcnt_d - v_act_beg;
                end
                line_start_q  <= (hcnt_d == '0);
                frame_start_q <= (hcnt_d == '0) && (vcnt_d == '0);
            end else begin
                frame_start_q <= 1'b0;
                line_start_q  <= 1'b0;
            end
        end
    end

`ifdef VGA_LINE_IRQ_EN
    logic [CW-1:0] lcmp_q;
    logic          line_irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcmp_q     <= '0;
            line_irq_q <= 1'b0;
        end else begin
            if (bus.cfg_wr && (bus.cfg_addr == 4'd8)) begin
                lcmp_q <= bus.cfg_wdata;
            end
            line_irq_q <= bus.en && (hcnt_d == '0) && (vcnt_d == lcmp_q);
        end
    end

    assign bus.line_irq = line_irq_q;
`else
    assign bus.line_irq = 1'b0;
`endif

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.cfg_pend    = pend_q;
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): CW, 16, counter/config field width; H_SYNC/H_BP/H_ACT/H_FP, 96/48/640/16, horizontal reset timing in pixel clocks; V_SYNC/V_BP/V_ACT/V_FP, 2/33/480/10, vertical reset timing in lines.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; the only clock.
- rst_n, in, 1, reset; synchronous, active-low.
- en, in, 1, count enable.
- cfg_wr, in, 1, shadow-register write strobe.
- cfg_addr, in, 4, register select.
- cfg_wdata, in, CW, write data.
- cfg_commit, in, 1, arm shadow-to-active transfer.
- hsync, out, 1, horizontal sync, active-low.
- vsync, out, 1, vertical sync, active-low.
- de, out, 1, active-video data enable.
- x, out, CW, active pixel column.
- y, out, CW, active line.
- frame_start, out, 1, one-cycle pulse at the first pixel of a frame.
- line_start, out, 1, one-cycle pulse at the first pixel of a line.
- cfg_pend, out, 1, commit armed and not yet applied.
- line_irq, out, 1, line-compare pulse.

Function
REQ-003 Internal counters hcnt (0..HTOT-1) and vcnt (0..VTOT-1) SHALL be used, where HTOT = hsync+hbp+hact+hfp and VTOT is the vertical equivalent, both taken from the active registers.
REQ-004 Segment order per line and per frame SHALL be sync, back porch, active, front porch.
REQ-005 When en=1, hcnt SHALL wrap to 0 after HTOT-1; vcnt SHALL advance only when hcnt wraps, and SHALL wrap to 0 after VTOT-1.
REQ-006 When en=0, the counters and all outputs SHALL hold; pulse outputs SHALL be 0.
REQ-007 All outputs SHALL be registered and SHALL be updated on the same edge as the counters, reflecting the new counter values (zero added latency).
REQ-008 The output decode SHALL be:
- hsync=0 iff hcnt<hsync_len.
- vsync=0 iff vcnt<vsync_len.
- de=1 iff both counters are in their active segments.
- x = hcnt-(hsync_len+hbp) and y = vcnt-(vsync_len+vbp) while de=1; x and y SHALL hold their last value otherwise.
REQ-009 line_start SHALL be 1 iff hcnt=0; frame_start SHALL be 1 iff hcnt=0 and vcnt=0.
REQ-010 The shadow register map SHALL be: cfg_addr 0-7 = H_SYNC, H_BP, H_ACT, H_FP, V_SYNC, V_BP, V_ACT, V_FP; a write SHALL take effect on the next cycle; a written value of 0 SHALL be stored as 1; writes to unmapped addresses SHALL be ignored.
REQ-011 cfg_commit SHALL set cfg_pend; the shadow registers SHALL be copied to the active registers on the last pixel of the frame (hcnt=HTOT-1, vcnt=VTOT-1, en=1), and that same edge SHALL clear cfg_pend; the next frame SHALL use the new timing from pixel 0.
REQ-012 Shadow writes while cfg_pend=1 SHALL be allowed, and the latest values SHALL be the ones copied.
REQ-013 A cfg_commit on the same cycle as the copy edge SHALL re-arm cfg_pend.
REQ-014 The active timing SHALL never change mid-frame.

Reset
REQ-015 On rst_n=0 at a clk edge, the block SHALL set: hcnt=vcnt=0; active and shadow registers = parameter defaults; cfg_pend=0; hsync=0, vsync=0, de=0, x=0, y=0, frame_start=0, line_start=0, line_irq=0.
REQ-016 Reset SHALL override en, cfg_wr and cfg_commit in the same cycle, including when asserted mid-frame.

Configuration
REQ-017 With VGA_LINE_IRQ_EN defined:
- cfg_addr 8 SHALL be the line-compare register lcmp (reset 0, written directly with no shadowing).
- line_irq SHALL pulse for one cycle when hcnt=0 and vcnt=lcmp.
REQ-018 Without VGA_LINE_IRQ_EN, line_irq SHALL be tied to 0, and cfg_addr 8 SHALL be ignored.

Verification
REQ-019 Defaults, en=1, 2 frames: line = 800 clocks; hsync low for hcnt 0-95; de high for hcnt 144-783 on lines 35-514; frame_start period 420000 clocks; x runs 0-639.
REQ-020 Write H_ACT=320, then commit at vcnt=100: cfg_pend=1 until the last pixel of the frame; the current frame keeps 800-clock lines; the next frame has 480-clock lines with de high for 320 clocks.
REQ-021 en=0 for 10 cycles at hcnt=300: hcnt, x, y and the sync outputs are unchanged and line_start=0; counting resumes at 301.
REQ-022 rst_n=0 for 1 cycle at hcnt=500, vcnt=200 after a shadow write: outputs take the REQ-015 values and the shadow registers read back as defaults; the next frame_start arrives 420000 clocks later.
REQ-023 Write 0 to V_FP, then commit: VTOT=516; the frame_start period becomes 412800.
REQ-024 VGA_LINE_IRQ_EN defined, lcmp=35: exactly one line_irq per frame, at vcnt=35, hcnt=0; macro undefined: line_irq=0 throughout.
